// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, CHUNK bits per clock,
// through one CHUNK-bit ripple slice and a registered inter-chunk carry.
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_chunk;

    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic [CHUNK:0]   ripple;

    // Handshake: start is sampled only in IDLE or DONE; an accepted start makes busy
    // high for N cycles, then done is high for exactly one cycle with s/c_out/overflow
    // valid. Results hold until the next accepted start. start during busy is ignored.

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign last_chunk = (idx == LAST_IDX);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign dbg_state  = state;

    // One CHUNK-bit ripple slice; ripple[CHUNK-1] is the carry into the slice MSB,
    // which on the final chunk is the carry into bit WIDTH-1.
    always_comb begin
        slice_a   = a_q[idx*CHUNK +: CHUNK];
        slice_b   = b_q[idx*CHUNK +: CHUNK];
        slice_sum = '0;
        ripple    = '0;
        ripple[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            slice_sum[i]  = slice_a[i] ^ slice_b[i] ^ ripple[i];
            ripple[i + 1] = (slice_a[i] & slice_b[i]) | (ripple[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            idx     <= '0;
            s       <= '0;
        end else if (state == RUN) begin
            s[idx*CHUNK +: CHUNK] <= slice_sum;
            carry_q               <= ripple[CHUNK];
            if (last_chunk) begin
                idx      <= '0;
                c_out    <= ripple[CHUNK];
                overflow <= ripple[CHUNK-1] ^ ripple[CHUNK];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
